pc_unit_ras: RTL and testbench

Parametrised program-counter unit for the lab CPU datapath. It is the successor of the 8-bit PC/branch block and generalises the PC width. It adds a stall input, an asynchronous active-low reset value, branch-with-link (call), and a return-address stack (RAS) with overflow/underflow detection. It sits between the FSM controller (stall/incp/call/ret), the instruction decoder (sximm, cond), the status register and the register file (A operand).

---
 rtl/pc_unit_ras.sv | 112 +++++++++++
 tb/tb_pc_unit_ras.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Program-counter unit with conditional/relative branches, branch-with-link
// and a circular return-address stack that flags overflow and underflow.
module pc_unit_ras #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           incp,
    input  logic                           execb,
    input  logic [2:0]                     cond,
    input  logic [2:0]                     status,
    input  logic                           tsel,
    input  logic [PC_W-1:0]                sximm,
    input  logic [PC_W-1:0]                a_in,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           clr_err,
    output logic [PC_W-1:0]                pc_out,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] RESET_PC_W = RESET_PC;
    localparam logic [PC_W-1:0] RESET_VAL = RESET_PC_W[PC_W-1:0];

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_nxt;
    logic [PTR_W-1:0] push_idx;
    logic [PC_W-1:0]  pc_nxt;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             push;
    logic             taken;

    assign taken     = execb & ((cond == 3'b000) | (cond == status));
    assign pc_inc    = pc_out + PC_W'(1);
    assign target    = tsel ? (pc_out + sximm) : a_in;
    assign push_idx  = top + PTR_W'(1);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);

    always_comb begin
        pc_nxt  = pc_out;
        top_nxt = top;
        cnt_nxt = ras_count;
        ovf_nxt = ras_ovf;
        unf_nxt = ras_unf;
        push    = 1'b0;
        if (!stall) begin
            // Clear first so an error raised on the same edge still sticks.
            if (clr_err) begin
                ovf_nxt = 1'b0;
                unf_nxt = 1'b0;
            end
            if (ret) begin
                if (!ras_empty) begin
                    pc_nxt  = ras_mem[top];
                    top_nxt = top - PTR_W'(1);
                    cnt_nxt = ras_count - CNT_W'(1);
                end else begin
                    pc_nxt  = pc_inc;
                    unf_nxt = 1'b1;
                end
            end else if (taken) begin
                pc_nxt = target;
                if (call) begin
                    push    = 1'b1;
                    top_nxt = push_idx;
                    // When full, push_idx lands on the oldest entry and replaces it.
                    if (ras_full) ovf_nxt = 1'b1;
                    else          cnt_nxt = ras_count + CNT_W'(1);
                end
            end else if (incp) begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out    <= RESET_VAL;
            top       <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc_out    <= pc_nxt;
            top       <= top_nxt;
            ras_count <= cnt_nxt;
            ras_ovf   <= ovf_nxt;
            ras_unf   <= unf_nxt;
        end
    end

    // Stack storage is not reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push) ras_mem[push_idx] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: increment/wrap, branches, call/return,
// RAS overflow/underflow, stall and ret/call priority.
module tb_pc_unit_ras;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, incp, execb, tsel, call, ret, clr_err;
    logic [2:0] cond, status;
    logic [7:0] sximm, a_in;
    logic [7:0] pc_out;
    logic [2:0] ras_count;
    logic       ras_full, ras_empty, ras_ovf, ras_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit_ras #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .incp(incp), .execb(execb),
        .cond(cond), .status(status), .tsel(tsel), .sximm(sximm), .a_in(a_in),
        .call(call), .ret(ret), .clr_err(clr_err), .pc_out(pc_out),
        .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    task automatic idle();
        stall = 0; incp = 0; execb = 0; tsel = 0; call = 0; ret = 0; clr_err = 0;
        cond = 3'b000; status = 3'b000; sximm = 8'h00; a_in = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        reset = 1;
    endtask

    // Absolute jump (or call) to dst on the next edge.
    task automatic jump(input logic [7:0] dst, input logic lnk);
        idle();
        execb = 1; cond = 3'b000; tsel = 0; a_in = dst; call = lnk;
        step();
        idle();
    endtask

    task automatic do_ret();
        idle();
        ret = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        #3;
        checks++;
        if (pc_out !== 8'h00 || ras_count !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h cnt=%0d ovf=%b unf=%b exp pc=00 cnt=0 ovf=0 unf=0",
                     pc_out, ras_count, ras_ovf, ras_unf);
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", ras_empty, ras_full);
        end
        step();
        reset = 1;
    endtask

    task automatic test_increment();
        logic [7:0] exp;
        idle();
        incp = 1;
        for (int i = 1; i <= 260; i++) begin
            step();
            exp = 8'(i);
            checks++;
            if (pc_out !== exp) begin
                errors++;
                $display("FAIL incr_%0d got %h exp %h", i, pc_out, exp);
            end
        end
        step();
        step();
        #2;
        reset = 0;
        #1;
        checks++;
        if (pc_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %h exp 00", pc_out);
        end
        step();
        reset = 1;
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        jump(8'h10, 0);
        checks++;
        if (pc_out !== 8'h10) begin
            errors++;
            $display("FAIL jump_abs got %h exp 10", pc_out);
        end
        execb = 1; cond = 3'b010; status = 3'b010; tsel = 1; sximm = 8'hFC;
        step();
        checks++;
        if (pc_out !== 8'h0C) begin
            errors++;
            $display("FAIL branch_rel_back got %h exp 0c", pc_out);
        end
        jump(8'h10, 0);
        execb = 1; cond = 3'b010; status = 3'b001; tsel = 1; sximm = 8'hFC; incp = 1;
        step();
        checks++;
        if (pc_out !== 8'h11) begin
            errors++;
            $display("FAIL branch_not_taken got %h exp 11", pc_out);
        end
        idle();
        execb = 1; cond = 3'b000; tsel = 0; a_in = 8'h80;
        step();
        checks++;
        if (pc_out !== 8'h80) begin
            errors++;
            $display("FAIL branch_always_abs got %h exp 80", pc_out);
        end
        jump(8'hF0, 0);
        execb = 1; cond = 3'b000; tsel = 1; sximm = 8'h20;
        step();
        checks++;
        if (pc_out !== 8'h10) begin
            errors++;
            $display("FAIL branch_rel_wrap got %h exp 10", pc_out);
        end
        idle();
        call = 1;
        step();
        checks++;
        if (pc_out !== 8'h10 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL call_no_taken pc=%h cnt=%0d exp pc=10 cnt=0", pc_out, ras_count);
        end
        idle();
    endtask

    task automatic test_call_chain();
        logic [7:0] tgt [3] = '{8'h20, 8'h40, 8'h60};
        logic [7:0] rpc [3] = '{8'h41, 8'h21, 8'h06};
        do_reset();
        jump(8'h05, 0);
        for (int i = 0; i < 3; i++) begin
            jump(tgt[i], 1);
            checks++;
            if (pc_out !== tgt[i] || ras_count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL call_%0d pc=%h cnt=%0d exp pc=%h cnt=%0d", i, pc_out, ras_count, tgt[i], i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_ret();
            checks++;
            if (pc_out !== rpc[i] || ras_count !== 3'(2 - i)) begin
                errors++;
                $display("FAIL ret_%0d pc=%h cnt=%0d exp pc=%h cnt=%0d", i, pc_out, ras_count, rpc[i], 2 - i);
            end
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL chain_empty empty=%b unf=%b exp empty=1 unf=0", ras_empty, ras_unf);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] pops [4] = '{8'h06, 8'h05, 8'h04, 8'h03};
        do_reset();
        jump(8'h01, 0);
        for (int i = 0; i < 5; i++) begin
            jump(8'(i + 2), 1);
            if (i == 3) begin
                checks++;
                if (ras_full !== 1'b1 || ras_ovf !== 1'b0 || ras_count !== 3'd4) begin
                    errors++;
                    $display("FAIL ovf_full full=%b ovf=%b cnt=%0d exp full=1 ovf=0 cnt=4", ras_full, ras_ovf, ras_count);
                end
            end
        end
        checks++;
        if (ras_ovf !== 1'b1 || ras_count !== 3'd4 || pc_out !== 8'h06) begin
            errors++;
            $display("FAIL ovf_set ovf=%b cnt=%0d pc=%h exp ovf=1 cnt=4 pc=06", ras_ovf, ras_count, pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            do_ret();
            checks++;
            if (pc_out !== pops[i]) begin
                errors++;
                $display("FAIL ovf_pop_%0d got %h exp %h", i, pc_out, pops[i]);
            end
        end
        do_ret();
        checks++;
        if (pc_out !== 8'h04 || ras_unf !== 1'b1 || ras_count !== 3'd0 || ras_ovf !== 1'b1) begin
            errors++;
            $display("FAIL unf_set pc=%h unf=%b cnt=%0d ovf=%b exp pc=04 unf=1 cnt=0 ovf=1",
                     pc_out, ras_unf, ras_count, ras_ovf);
        end
        clr_err = 1;
        step();
        checks++;
        if (ras_ovf !== 1'b0 || ras_unf !== 1'b0 || pc_out !== 8'h04) begin
            errors++;
            $display("FAIL clr_err ovf=%b unf=%b pc=%h exp ovf=0 unf=0 pc=04", ras_ovf, ras_unf, pc_out);
        end
        clr_err = 1; ret = 1;
        step();
        checks++;
        if (ras_unf !== 1'b1 || pc_out !== 8'h05) begin
            errors++;
            $display("FAIL set_wins unf=%b pc=%h exp unf=1 pc=05", ras_unf, pc_out);
        end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        do_ret();
        jump(8'h30, 1);
        checks++;
        if (pc_out !== 8'h30 || ras_count !== 3'd1 || ras_unf !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup pc=%h cnt=%0d unf=%b exp pc=30 cnt=1 unf=1", pc_out, ras_count, ras_unf);
        end
        stall = 1; incp = 1; call = 1; execb = 1; cond = 3'b000; tsel = 0; a_in = 8'h50; clr_err = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_out !== 8'h30 || ras_count !== 3'd1 || ras_unf !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d pc=%h cnt=%0d unf=%b exp pc=30 cnt=1 unf=1",
                         i, pc_out, ras_count, ras_unf);
            end
        end
        stall = 0;
        step();
        checks++;
        if (pc_out !== 8'h50 || ras_count !== 3'd2 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL stall_release pc=%h cnt=%0d unf=%b exp pc=50 cnt=2 unf=0", pc_out, ras_count, ras_unf);
        end
        idle();
        do_ret();
        checks++;
        if (pc_out !== 8'h31) begin
            errors++;
            $display("FAIL stall_ret got %h exp 31", pc_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        jump(8'h10, 1);
        jump(8'h20, 1);
        checks++;
        if (ras_count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 2", ras_count);
        end
        ret = 1; call = 1; execb = 1; cond = 3'b000; tsel = 0; a_in = 8'h70;
        step();
        checks++;
        if (pc_out !== 8'h11 || ras_count !== 3'd1 || ras_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ret_priority pc=%h cnt=%0d ovf=%b exp pc=11 cnt=1 ovf=0", pc_out, ras_count, ras_ovf);
        end
        step();
        checks++;
        if (pc_out !== 8'h01 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL ret_priority2 pc=%h cnt=%0d exp pc=01 cnt=0", pc_out, ras_count);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_increment();
        test_branch();
        test_call_chain();
        test_overflow();
        test_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
